// File: rtl/mem_traffic_pkg.sv
// Shared encodings and constants for the memory traffic generator/checker.
package mem_traffic_pkg;

  typedef enum logic [1:0] {
    MODE_INCR    = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_INVADDR = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] ERR_SAT   = 16'hFFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/mem_traffic_pattern.sv
// Per-word data pattern generator; one copy drives write data, another regenerates
// expected read data so the checker never relies on what was written.
module mem_traffic_pattern
  import mem_traffic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 24,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  mode_e             mode_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              restart_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] pattern_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] inv_addr;
  logic [31:0]       idx_ext, inv_ext;

  always_comb begin
    lfsr_d = lfsr_q;
    if (restart_i) begin
      lfsr_d = lfsr_seed(SEED);
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= lfsr_seed(SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Invert at address width first so narrow addresses zero-extend
  always_comb begin
    inv_addr  = ~addr_i;
    idx_ext   = 32'(index_i);
    inv_ext   = 32'(inv_addr);
    pattern_o = '0;
    case (mode_i)
      MODE_INCR: pattern_o = idx_ext[DATA_W-1:0];
      MODE_WALK: pattern_o = {{(DATA_W-1){1'b0}}, 1'b1} << index_i[SH_W-1:0];
      MODE_LFSR: pattern_o = lfsr_q[DATA_W-1:0];
      default:   pattern_o = inv_ext[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/mem_traffic_checker.sv
// Memory traffic generator/checker: writes a pattern over a word range, reads it back in order
// and counts mismatches. Define MEM_TRAFFIC_CHECKER_ERRLOG_EN to add first-mismatch log ports.
module mem_traffic_checker
  import mem_traffic_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = 32'hACE1_2468
) (
  input  logic                CLK_50M,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_words,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid
`ifdef MEM_TRAFFIC_CHECKER_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_exp,
  output logic [DATA_W-1:0]   err_act
`endif
);

  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [ADDR_W-1:0] base_q, num_q, wr_idx_q, rd_idx_q, chk_idx_q;
  logic [3:0]        outst_q;
  logic [15:0]       err_q;
  logic              busy_q, done_q, pass_q;

  logic              start_go, wr_acc, rd_can, rd_acc, rsp, rsp_dec, mismatch;
  logic              last_wr, last_rd;
  logic [ADDR_W-1:0] wr_addr, rd_addr, chk_addr;
  logic [DATA_W-1:0] wr_pat, chk_pat;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == ERR_SAT) ? v : v + 16'd1;
  endfunction

  assign start_go = start && (state_q == IDLE);
  assign wr_addr  = base_q + wr_idx_q;
  assign rd_addr  = base_q + rd_idx_q;
  assign chk_addr = base_q + chk_idx_q;
  assign last_wr  = (wr_idx_q == num_q - ONE_A);
  assign last_rd  = (rd_idx_q == num_q - ONE_A);
  assign rd_can   = (rd_idx_q != num_q) && (outst_q < MAX_OUT);
  assign wr_acc   = (state_q == WRITE) && mem_ready;
  assign rd_acc   = (state_q == READ) && rd_can && mem_ready;
  assign rsp      = mem_rvalid && ((state_q == READ) || (state_q == DRAIN));
  assign rsp_dec  = rsp && (outst_q != 4'd0);
  assign mismatch = rsp && (mem_rdata != chk_pat);

  mem_traffic_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_wr_pat (
    .clk_i     (CLK_50M),
    .rst_ni    (rst_n),
    .mode_i    (mode_q),
    .index_i   (wr_idx_q),
    .addr_i    (wr_addr),
    .restart_i (start_go),
    .advance_i (wr_acc),
    .pattern_o (wr_pat)
  );

  mem_traffic_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) u_chk_pat (
    .clk_i     (CLK_50M),
    .rst_ni    (rst_n),
    .mode_i    (mode_q),
    .index_i   (chk_idx_q),
    .addr_i    (chk_addr),
    .restart_i (start_go),
    .advance_i (rsp),
    .pattern_o (chk_pat)
  );

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = (num_words == '0) ? DONE : WRITE;
      WRITE:   if (wr_acc && last_wr) state_d = READ;
      READ:    if (rd_acc && last_rd) state_d = DRAIN;
      DRAIN:   if (outst_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request side is a pure function of registered state, so it holds while mem_ready is low
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_pat;
      end
      READ: begin
        mem_req  = rd_can;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_INCR;
      base_q    <= '0;
      num_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      chk_idx_q <= '0;
      outst_q   <= 4'd0;
      err_q     <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      if (start_go) begin
        mode_q    <= mode_e'(mode);
        base_q    <= base_addr;
        num_q     <= num_words;
        wr_idx_q  <= '0;
        rd_idx_q  <= '0;
        chk_idx_q <= '0;
        outst_q   <= 4'd0;
        err_q     <= 16'd0;
        busy_q    <= 1'b1;
        pass_q    <= 1'b0;
      end else begin
        if (wr_acc) wr_idx_q <= wr_idx_q + ONE_A;
        if (rd_acc) rd_idx_q <= rd_idx_q + ONE_A;
        if (rsp) chk_idx_q <= chk_idx_q + ONE_A;
        case ({rd_acc, rsp_dec})
          2'b10:   outst_q <= outst_q + 4'd1;
          2'b01:   outst_q <= outst_q - 4'd1;
          default: ;
        endcase
        if (mismatch) err_q <= sat_inc(err_q);
        if (state_q == DONE) begin
          busy_q <= 1'b0;
          pass_q <= (err_q == 16'd0);
        end
      end
      done_q <= (state_q == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign mem_be    = '1;

`ifdef MEM_TRAFFIC_CHECKER_ERRLOG_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_exp_q, err_act_q;

  // A zero error count marks the first mismatch since start
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else if (start_go) begin
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else if (mismatch && (err_q == 16'd0)) begin
      err_addr_q <= chk_addr;
      err_exp_q  <= chk_pat;
      err_act_q  <= mem_rdata;
    end
  end

  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_act  = err_act_q;
`endif

endmodule

// File: tb/tb_mem_traffic_checker.sv
// Directed bench for mem_traffic_checker with a behavioural in-order memory model.
module tb_mem_traffic_checker;
  localparam int DW = 16;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr, num_words;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
`ifdef MEM_TRAFFIC_CHECKER_ERRLOG_EN
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_act;
`endif

  always #10 clk = ~clk;

  mem_traffic_checker #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTSTANDING(2), .SEED(32'hACE1_2468)) dut (
    .CLK_50M    (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef MEM_TRAFFIC_CHECKER_ERRLOG_EN
    ,
    .err_addr   (err_addr),
    .err_exp    (err_exp),
    .err_act    (err_act)
`endif
  );

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [AW-1:0] rd_a[$];
  logic [DW-1:0] rsp_d[$];
  int            rsp_t[$];
  int            cyc = 0, lat = 1, out_cnt = 0, max_out = 0, req_cnt = 0;
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [DW-1:0] flip_mask = '0;
  int            n_chk = 0, n_pass = 0, n_fail = 0;

  // Memory model: capture accepted requests on the rising edge
  always @(posedge clk) begin
    logic [DW-1:0] d;
    cyc++;
    if (rst_n) begin
      if (mem_req) req_cnt++;
      if (mem_rvalid && rsp_d.size() > 0) begin
        void'(rsp_d.pop_front());
        void'(rsp_t.pop_front());
        out_cnt--;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_a.push_back(mem_addr);
          wr_d.push_back(mem_wdata);
        end else begin
          d = mem.exists(mem_addr) ? mem[mem_addr] : '0;
          if (flip_en && mem_addr == flip_addr) d = d ^ flip_mask;
          rd_a.push_back(mem_addr);
          rsp_d.push_back(d);
          rsp_t.push_back(cyc + lat - 1);
          out_cnt++;
        end
      end
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  always @(negedge clk) begin
    if (rsp_d.size() > 0 && rsp_t[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rsp_d[0];
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask

  task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(negedge clk);
    mode = m; base_addr = b; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output logic got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          got;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    int            bad;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; num_words = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_err", err_count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("be_ones", mem_be, 2'b11);
    rst_n = 1'b1;

    // Mode 0 incrementing, ideal memory
    clear_logs();
    run(2'd0, 24'h000100, 24'd16);
    chk("t1_busy", busy, 1);
    wait_done(400, got);
    chk("t1_done", got, 1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_busy_clr", busy, 0);
    bad = 0;
    if (wr_a.size() != 16 || rd_a.size() != 16) bad = 99;
    else for (int i = 0; i < 16; i++) begin
      if (wr_a[i] != 24'(32'h100 + i)) bad++;
      if (wr_d[i] != 16'(i)) bad++;
      if (rd_a[i] != 24'(32'h100 + i)) bad++;
    end
    chk("t1_seq", bad, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Mode 1 walking one, bit 3 of word 5 corrupted on readback
    clear_logs();
    flip_en = 1'b1; flip_addr = 24'h000045; flip_mask = 16'h0008;
    run(2'd1, 24'h000040, 24'd20);
    wait_done(400, got);
    flip_en = 1'b0;
    chk("t2_done", got, 1);
    chk("t2_err", err_count, 1);
    chk("t2_pass", pass, 0);
    chk("t2_wd5", (wr_d.size() > 17) ? wr_d[5] : 16'hDEAD, 16'h0020);
    chk("t2_wd16", (wr_d.size() > 17) ? wr_d[16] : 16'hDEAD, 16'h0001);
    chk("t2_wd17", (wr_d.size() > 17) ? wr_d[17] : 16'hDEAD, 16'h0002);
`ifdef MEM_TRAFFIC_CHECKER_ERRLOG_EN
    chk("t2_err_addr", err_addr, 24'h000045);
    chk("t2_err_exp", err_exp, 16'h0020);
    chk("t2_err_act", err_act, 16'h0028);
`endif

    // Write stall: mem_ready low for 7 cycles after three writes
    clear_logs();
    run(2'd0, 24'h000200, 24'd10);
    for (int i = 0; i < 100; i++) begin
      if (wr_a.size() >= 3) break;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    a0 = mem_addr; d0 = mem_wdata;
    chk("t3_reach", wr_a.size(), 3);
    chk("t3_addr", a0, 24'h000203);
    chk("t3_wdata", d0, 16'h0003);
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (!mem_req || !mem_we || mem_addr != a0 || mem_wdata != d0) bad++;
    end
    chk("t3_stable", bad, 0);
    chk("t3_no_accept", wr_a.size(), 3);
    mem_ready = 1'b1;
    wait_done(400, got);
    chk("t3_done", got, 1);
    chk("t3_pass", pass, 1);
    bad = 0;
    if (wr_a.size() != 10) bad = 99;
    else for (int i = 0; i < 10; i++) if (wr_a[i] != 24'(32'h200 + i)) bad++;
    chk("t3_seq", bad, 0);

    // Mode 2 LFSR, 6-cycle read latency, outstanding limit 2
    clear_logs();
    lat = 6; max_out = 0;
    run(2'd2, 24'h001000, 24'd32);
    wait_done(2000, got);
    lat = 1;
    chk("t4_done", got, 1);
    chk("t4_pass", pass, 1);
    chk("t4_err", err_count, 0);
    chk("t4_max_out", max_out, 2);
    chk("t4_nrd", rd_a.size(), 32);
    chk("t4_wd0", (wr_d.size() > 4) ? wr_d[0] : 16'hDEAD, 16'h2468);
    chk("t4_wd1", (wr_d.size() > 4) ? wr_d[1] : 16'hDEAD, 16'h9234);
    chk("t4_wd2", (wr_d.size() > 4) ? wr_d[2] : 16'hDEAD, 16'h491A);
    chk("t4_wd3", (wr_d.size() > 4) ? wr_d[3] : 16'hDEAD, 16'h248D);
    chk("t4_wd4", (wr_d.size() > 4) ? wr_d[4] : 16'hDEAD, 16'h1245);

    // Mode 3 inverted address with wrap past all-ones
    clear_logs();
    run(2'd3, 24'hFFFFFE, 24'd4);
    wait_done(200, got);
    chk("t5_done", got, 1);
    chk("t5_pass", pass, 1);
    bad = 0;
    if (wr_a.size() != 4 || rd_a.size() != 4) bad = 99;
    else begin
      if (wr_a[0] != 24'hFFFFFE || wr_a[1] != 24'hFFFFFF) bad++;
      if (wr_a[2] != 24'h000000 || wr_a[3] != 24'h000001) bad++;
      if (rd_a[2] != 24'h000000 || rd_a[3] != 24'h000001) bad++;
    end
    chk("t5_addrs", bad, 0);
    chk("t5_wd0", (wr_d.size() == 4) ? wr_d[0] : 16'hDEAD, 16'h0001);
    chk("t5_wd2", (wr_d.size() == 4) ? wr_d[2] : 16'hDEAD, 16'hFFFF);

    // Zero-length run
    clear_logs();
    req_cnt = 0;
    run(2'd0, 24'h000500, 24'd0);
    chk("t6_done_early", done, 0);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_pass", pass, 1);
    chk("t6_err", err_count, 0);
    chk("t6_no_req", req_cnt, 0);

    // Reset asserted in the middle of the read phase
    clear_logs();
    lat = 6;
    run(2'd0, 24'h000600, 24'd16);
    for (int i = 0; i < 400; i++) begin
      if (rd_a.size() >= 3) break;
      @(negedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_req", mem_req, 0);
    chk("t7_we", mem_we, 0);
    chk("t7_addr", mem_addr, 0);
    chk("t7_wdata", mem_wdata, 0);
    chk("t7_err", err_count, 0);
    rsp_d.delete();
    rsp_t.delete();
    out_cnt = 0;
    lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run after the abort
    clear_logs();
    run(2'd0, 24'h000700, 24'd8);
    wait_done(400, got);
    chk("t8_done", got, 1);
    chk("t8_pass", pass, 1);
    chk("t8_err", err_count, 0);
    chk("t8_first", (wr_a.size() > 0) ? wr_a[0] : 24'hDEAD00, 24'h000700);
    chk("t8_nrd", rd_a.size(), 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_traffic_checker.md
Name: mem_traffic_checker

Overview:
- Parametrised memory traffic generator and checker for the bemicro OR1K platform.
- Writes a selectable data pattern over an address range through a generic req/ready memory port, then reads it back and compares it.
- Reports pass/fail and an error count.
- Sits in front of the mobile-DDR controller's user port, in simulation benches and as an on-board self-test.

Parameters:
- DATA_W, 16, data width; legal values 8/16/32.
- ADDR_W, 24, word address width.
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads; legal range 1..15.
- SEED, 32'hACE1_2468, LFSR seed; a zero value is forced to 1.

Ports:
- CLK_50M  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- mode  in  2  pattern select: 0 incr, 1 walking-one, 2 LFSR, 3 inverted address.
- base_addr  in  ADDR_W  first word address; sampled on start.
- num_words  in  ADDR_W  number of words; sampled on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result; valid from done until the next start.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables; always all ones.
- mem_ready  in  1  request accepted when mem_req && mem_ready.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read data valid; responses return in order.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE.
  - busy, done, pass, mem_req, mem_we all 0.
  - err_count, mem_addr, mem_wdata all 0.
  - All counters cleared; both LFSRs loaded with SEED.
- Address generation: address of word i is base_addr + i, modulo 2^ADDR_W. Wrap-around past all-ones is legal.
- Pattern for word i:
  - Mode 0: i[DATA_W-1:0].
  - Mode 1: 1 << (i mod DATA_W).
  - Mode 2: low DATA_W bits of a 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1. The LFSR advances once per word.
  - Mode 3: ~addr[DATA_W-1:0], zero-extended if ADDR_W < DATA_W.
- Pattern generators: separate write-side and check-side generators, both restarted on start, so the check side regenerates the expected data independently.
- IDLE state:
  - On start with num_words = 0: go to DONE; done pulses the next cycle with pass = 1 and err_count = 0.
  - On start with num_words != 0: go to WRITE, clear err_count, set busy.
- WRITE state:
  - mem_req = 1, mem_we = 1.
  - addr/wdata advance only on an accepted transfer (mem_req && mem_ready).
  - All request outputs are held stable while mem_ready = 0.
  - After the last write is accepted: go to READ. mem_req drops for at most one cycle between phases.
- READ state:
  - Issue reads while issued_count < num_words and outstanding < MAX_OUTSTANDING.
  - outstanding increments on acceptance, decrements on mem_rvalid. Simultaneous acceptance and mem_rvalid leaves it unchanged.
  - When the limit is reached, mem_req deasserts until a response frees a slot.
  - After the last read is issued: go to DRAIN.
- DRAIN state: wait for outstanding = 0.
- Checking:
  - Every mem_rvalid in READ or DRAIN is compared with the check-side pattern.
  - Each mismatch increments err_count (saturating).
  - mem_rvalid in IDLE, WRITE or DONE is ignored.
- DONE state:
  - Entered one cycle after the final response is compared.
  - done pulses for 1 cycle; pass = (err_count == 0); busy clears; return to IDLE.
- Other rules:
  - start while busy is ignored, with no effect on sampled inputs.
  - Reset during any state aborts immediately. A pending memory transaction is abandoned, and the memory side must tolerate this.

Optional Feature:
- Macro: MEM_TRAFFIC_CHECKER_ERRLOG_EN.
- When defined, adds three outputs:
  - err_addr (ADDR_W), err_exp (DATA_W), err_act (DATA_W).
  - They capture the address, expected data and actual data of the first mismatch after start, and hold until the next start.
  - All three reset to 0, and are cleared on start.
- When undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package mem_traffic_pkg:
  - mode encodings MODE_INCR/MODE_WALK/MODE_LFSR/MODE_INVADDR.
  - state enum IDLE/WRITE/READ/DRAIN/DONE.
  - LFSR tap constant 32'h8020_0003.
  - err_count saturation constant.
- One sub-module, mem_traffic_pattern:
  - Inputs: mode, index, address, restart, advance.
  - Output: pattern word.
  - Instantiated twice (write side and check side).

Test Plan:
- Mode 0, base 0x000100, 16 words, ideal 1-cycle memory model:
  - 16 writes, then 16 reads at 0x100..0x10F with data 0..15.
  - done, pass = 1, err_count = 0.
- Mode 1, DATA_W = 16, 20 words, model flips bit 3 of word 5 on readback:
  - err_count = 1, pass = 0.
  - With ERRLOG_EN: err_addr = base+5, err_exp = 16'h0020, err_act = 16'h0028.
- mem_ready held low 7 cycles mid-write:
  - mem_req/mem_addr/mem_wdata stable throughout.
  - No address skipped or duplicated.
- Mode 2, read latency 6 cycles, MAX_OUTSTANDING = 2, 32 words:
  - outstanding never exceeds 2; pass = 1.
- Mode 3, base 0xFFFFFE, 4 words:
  - Addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; pass = 1.
- Edge cases:
  - num_words = 0: done exactly one cycle after entering DONE, pass = 1, no mem_req.
  - Reset asserted mid-READ: all outputs 0 asynchronously.
  - A subsequent start runs cleanly.
